// File: rtl/tblink_rpc_pkt_buf.sv
// tblink_rpc_pkt_buf: store-and-forward byte buffer that releases a packet only once it is fully stored
module tblink_rpc_pkt_buf #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  uclock,
    input  logic                  reset,
    input  logic [7:0]            t_dat,
    input  logic                  t_valid,
    output logic                  t_ready,
    output logic [7:0]            i_dat,
    output logic                  i_valid,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   pkt_count,
    output logic                  drop_o
);
    localparam int PW = DEPTH_LOG2 + 1;
    typedef enum logic [1:0] {W_DST, W_LEN, W_PAY, W_DROP} wst_t;
    typedef enum logic [1:0] {R_DST, R_LEN, R_PAY} rst_t;
    logic [7:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, cnt_q, cnt_d;
    wst_t ws_q, ws_d;
    rst_t rs_q, rs_d;
    logic [7:0] wrem_q, wrem_d, rrem_q, rrem_d;
    logic drop_q, drop_d, en_q;
    logic full, t_fire, r_fire, we, commit, last, too_long;
    always_comb begin
        full = (wr_q - rd_q) == PW'(2**DEPTH_LOG2);
        t_ready = en_q && (ws_q == W_DROP || !full);
        i_valid = rd_q != cm_q;
        i_dat = mem_q[rd_q[DEPTH_LOG2-1:0]];
        t_fire = t_valid && t_ready;
        r_fire = i_valid && i_ready;
        too_long = int'(t_dat) + 2 > 2**DEPTH_LOG2;
        wr_d = wr_q;
        ws_d = ws_q;
        wrem_d = wrem_q;
        drop_d = 1'b0;
        we = 1'b0;
        commit = 1'b0;
        if (t_fire) begin
            case (ws_q)
                W_DST: begin
                    we = 1'b1;
                    wr_d = wr_q + PW'(1);
                    ws_d = W_LEN;
                end
                W_LEN: begin
                    // An oversize packet rewinds to the last commit, discarding its stored dst byte
                    we = !too_long;
                    wr_d = too_long ? cm_q : wr_q + PW'(1);
                    drop_d = too_long;
                    wrem_d = t_dat;
                    commit = !too_long && t_dat == 8'd0;
                    ws_d = too_long ? W_DROP : (t_dat == 8'd0 ? W_DST : W_PAY);
                end
                W_PAY: begin
                    we = 1'b1;
                    wr_d = wr_q + PW'(1);
                    wrem_d = wrem_q - 8'd1;
                    commit = wrem_q == 8'd1;
                    ws_d = wrem_q == 8'd1 ? W_DST : W_PAY;
                end
                default: begin
                    wrem_d = wrem_q - 8'd1;
                    ws_d = wrem_q == 8'd1 ? W_DST : W_DROP;
                end
            endcase
        end
        cm_d = commit ? wr_d : cm_q;
        rd_d = r_fire ? rd_q + PW'(1) : rd_q;
        rs_d = rs_q;
        rrem_d = rrem_q;
        last = 1'b0;
        if (r_fire) begin
            case (rs_q)
                R_DST: rs_d = R_LEN;
                R_LEN: begin
                    rrem_d = i_dat;
                    last = i_dat == 8'd0;
                    rs_d = i_dat == 8'd0 ? R_DST : R_PAY;
                end
                default: begin
                    rrem_d = rrem_q - 8'd1;
                    last = rrem_q == 8'd1;
                    rs_d = rrem_q == 8'd1 ? R_DST : R_PAY;
                end
            endcase
        end
        cnt_d = cnt_q + PW'(commit) - PW'(last);
    end
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            cm_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            ws_q <= W_DST;
            rs_q <= R_DST;
            wrem_q <= '0;
            rrem_q <= '0;
            drop_q <= 1'b0;
            en_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            cm_q <= cm_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            ws_q <= ws_d;
            rs_q <= rs_d;
            wrem_q <= wrem_d;
            rrem_q <= rrem_d;
            drop_q <= drop_d;
            en_q <= 1'b1;
        end
    end
    always_ff @(posedge uclock) begin
        if (we) mem_q[wr_q[DEPTH_LOG2-1:0]] <= t_dat;
    end
    assign pkt_count = cnt_q;
    assign drop_o = drop_q;
endmodule

// File: tb/tb_tblink_rpc_pkt_buf.sv
// tb_tblink_rpc_pkt_buf: randomized and directed checks of the packet buffer against a packet-level queue model
module tb_tblink_rpc_pkt_buf;
    localparam int DL = 3;
    localparam int DEPTH = 8;
    logic uclock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] t_dat = 8'd0;
    logic t_valid = 1'b0;
    logic i_ready = 1'b0;
    logic t_ready, i_valid, drop_o;
    logic [7:0] i_dat;
    logic [DL:0] pkt_count;
    tblink_rpc_pkt_buf #(.DEPTH_LOG2(DL)) dut (
        .uclock(uclock), .reset(reset), .t_dat(t_dat), .t_valid(t_valid), .t_ready(t_ready),
        .i_dat(i_dat), .i_valid(i_valid), .i_ready(i_ready), .pkt_count(pkt_count), .drop_o(drop_o)
    );
    always #5 uclock = ~uclock;
    int n_chk = 0;
    int n_fail = 0;
    int drops_seen = 0;
    bit rnd_rd = 1'b0;
    logic [7:0] cq[$], pq[$], rxq[$], exp_q[$], tx_q[$];
    int pk[$];
    int in_pos = 0, in_len = 0, drop_left = 0;
    bit dropping = 1'b0, m_en = 1'b0, m_drop = 1'b0, tf, rf;
    function automatic bit m_tready();
        return m_en && (dropping || (cq.size() + pq.size()) < DEPTH);
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic commit_pkt();
        foreach (pq[i]) cq.push_back(pq[i]);
        pk.push_back(pq.size());
        pq.delete();
        in_pos = 0;
    endtask
    // Packet-level model: committed bytes, the packet being received, and per-packet unread byte counts
    always @(posedge uclock or posedge reset) begin
        if (reset) begin
            cq.delete();
            pq.delete();
            pk.delete();
            in_pos = 0;
            dropping = 1'b0;
            drop_left = 0;
            m_en = 1'b0;
            m_drop = 1'b0;
        end else begin
            if (i_valid && i_ready) rxq.push_back(i_dat);
            tf = t_valid && m_tready();
            rf = i_ready && cq.size() > 0;
            m_drop = 1'b0;
            if (rf) begin
                void'(cq.pop_front());
                pk[0]--;
                if (pk[0] == 0) void'(pk.pop_front());
            end
            if (tf) begin
                if (dropping) begin
                    drop_left--;
                    if (drop_left == 0) dropping = 1'b0;
                end else if (in_pos == 0) begin
                    pq.push_back(t_dat);
                    in_pos = 1;
                end else if (in_pos == 1) begin
                    if (int'(t_dat) + 2 > DEPTH) begin
                        pq.delete();
                        m_drop = 1'b1;
                        dropping = 1'b1;
                        drop_left = t_dat;
                        in_pos = 0;
                    end else begin
                        pq.push_back(t_dat);
                        in_len = t_dat;
                        if (t_dat == 8'd0) commit_pkt(); else in_pos = 2;
                    end
                end else begin
                    pq.push_back(t_dat);
                    if (pq.size() == in_len + 2) commit_pkt();
                end
            end
            m_en = 1'b1;
        end
    end
    always @(negedge uclock) begin
        if (!reset) begin
            chk("t_ready", t_ready, m_tready());
            chk("i_valid", i_valid, cq.size() > 0);
            if (cq.size() > 0) chk("i_dat", i_dat, cq[0]);
            chk("pkt_count", pkt_count, pk.size());
            chk("drop_o", drop_o, m_drop);
            if (drop_o) drops_seen++;
        end
    end
    initial forever begin
        @(negedge uclock);
        if (rnd_rd) i_ready = 1'($urandom_range(0, 1));
    end
    task automatic send_byte(input logic [7:0] b);
        int c = 0;
        t_valid = 1'b1;
        t_dat = b;
        while (!t_ready && c < 2000) begin
            @(negedge uclock);
            c++;
        end
        if (c >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: byte %0h not accepted within 2000 cycles", b);
        end
        @(negedge uclock);
        t_valid = 1'b0;
    endtask
    task automatic send_tx(input bit gaps);
        while (tx_q.size() > 0) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge uclock);
            send_byte(tx_q.pop_front());
        end
    endtask
    task automatic drain();
        int c = 0;
        while ((cq.size() > 0 || pk.size() > 0) && c < 3000) begin
            @(negedge uclock);
            c++;
        end
        if (c >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes still buffered", cq.size());
        end
        @(negedge uclock);
    endtask
    task automatic check_rx(input string name);
        chk({name, "_len"}, rxq.size(), exp_q.size());
        for (int i = 0; i < rxq.size() && i < exp_q.size(); i++) chk({name, "_byte"}, rxq[i], exp_q[i]);
        rxq.delete();
    endtask
    initial begin
        repeat (3) @(negedge uclock);
        chk("rst_t_ready", t_ready, 0);
        chk("rst_i_valid", i_valid, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_drop", drop_o, 0);
        reset = 1'b0;
        #1 chk("rel_t_ready", t_ready, 0);
        @(negedge uclock);
        // Single packet streamed straight through
        i_ready = 1'b1;
        tx_q = {8'h01, 8'h02, 8'haa, 8'hbb};
        send_tx(0);
        chk("t1_cnt", pkt_count, 1);
        chk("t1_valid", i_valid, 1);
        chk("t1_dat0", i_dat, 8'h01);
        @(negedge uclock); chk("t1_dat1", i_dat, 8'h02);
        @(negedge uclock); chk("t1_dat2", i_dat, 8'haa);
        @(negedge uclock); chk("t1_dat3", i_dat, 8'hbb);
        @(negedge uclock); chk("t1_cnt_end", pkt_count, 0);
        drain();
        exp_q = {8'h01, 8'h02, 8'haa, 8'hbb};
        check_rx("t1_rx");
        // Fill to capacity, then release the reader
        i_ready = 1'b0;
        tx_q = {8'h02, 8'h06, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send_tx(0);
        chk("t2_full_ready", t_ready, 0);
        chk("t2_cnt", pkt_count, 1);
        i_ready = 1'b1;
        tx_q = {8'h02, 8'h00};
        send_tx(0);
        drain();
        exp_q = {8'h02, 8'h06, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h02, 8'h00};
        check_rx("t2_rx");
        // Oversize packet is swallowed
        begin
            int d0 = drops_seen;
            tx_q = {8'h01, 8'h07};
            send_tx(0);
            chk("t3_drop_pulse", drop_o, 1);
            tx_q = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
            send_tx(0);
            @(negedge uclock);
            @(negedge uclock);
            chk("t3_drop_count", drops_seen - d0, 1);
            chk("t3_cnt", pkt_count, 0);
            chk("t3_valid", i_valid, 0);
            chk("t3_rx_empty", rxq.size(), 0);
        end
        tx_q = {8'h01, 8'h00};
        send_tx(0);
        drain();
        exp_q = {8'h01, 8'h00};
        check_rx("t3_rx");
        // Zero-length packet
        i_ready = 1'b0;
        tx_q = {8'h05, 8'h00};
        send_tx(0);
        chk("t4_cnt", pkt_count, 1);
        i_ready = 1'b1;
        drain();
        chk("t4_cnt_end", pkt_count, 0);
        exp_q = {8'h05, 8'h00};
        check_rx("t4_rx");
        // Commit of B on the same edge as the last read of A
        i_ready = 1'b0;
        tx_q = {8'h01, 8'h01, 8'h11, 8'h02};
        send_tx(0);
        chk("t5_cnt_pre", pkt_count, 1);
        i_ready = 1'b1;
        @(negedge uclock);
        @(negedge uclock);
        t_valid = 1'b1;
        t_dat = 8'h00;
        @(negedge uclock);
        t_valid = 1'b0;
        chk("t5_cnt_same", pkt_count, 1);
        chk("t5_next_dst", i_dat, 8'h02);
        drain();
        exp_q = {8'h01, 8'h01, 8'h11, 8'h02, 8'h00};
        check_rx("t5_rx");
        // Reset in the middle of a packet
        i_ready = 1'b0;
        tx_q = {8'h01, 8'h03, 8'haa};
        send_tx(0);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_t_ready", t_ready, 0);
        chk("t6_rst_i_valid", i_valid, 0);
        chk("t6_rst_cnt", pkt_count, 0);
        chk("t6_rst_drop", drop_o, 0);
        @(negedge uclock);
        @(negedge uclock);
        reset = 1'b0;
        #1 chk("t6_rel_t_ready", t_ready, 0);
        @(negedge uclock);
        rxq.delete();
        i_ready = 1'b1;
        tx_q = {8'h02, 8'h01, 8'hcc};
        send_tx(0);
        drain();
        exp_q = {8'h02, 8'h01, 8'hcc};
        check_rx("t6_rx");
        // Random packets, some oversize, with random gaps and reader stalls
        rnd_rd = 1'b1;
        for (int p = 0; p < 150; p++) begin
            int n = $urandom_range(0, 9);
            tx_q.push_back(8'($urandom));
            tx_q.push_back(8'(n));
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            send_tx(1);
        end
        rnd_rd = 1'b0;
        i_ready = 1'b1;
        drain();
        chk("rnd_cnt_end", pkt_count, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
